// File: rtl/xillybus_bridge_pkg.sv
// Shared definitions for the Xillybus host-to-PL prefetch bridge:
// default widths, the session FSM encoding and a pointer-width helper.
package xillybus_bridge_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 2;
    localparam int CNT_W_DEFAULT = 32;

    // Session state: CLOSED while the host file is not open, RUN otherwise.
    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Bits needed to index n entries, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bridge_prefetch_buf.sv
// DEPTH-entry register ring for the prefetch bridge. Pushes write at the
// tail, pops advance the head; both may happen in the same cycle, including
// when exactly one word is held. A synchronous clear empties the ring.
module bridge_prefetch_buf
    import xillybus_bridge_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = clog2_min1(DEPTH),
    localparam int OW   = clog2_min1(DEPTH + 1)
) (
    input  logic          bus_clk,
    input  logic          bus_rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          not_empty,
    output logic [OW-1:0] occupancy
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_pop;
    logic [OW-1:0] occupancy_next;

    // Wrap-around increment that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // A pop of an empty ring is meaningless; ignore it here as well.
    assign do_pop = pop & not_empty;

    // Next occupancy from the push/pop pair; push+pop leaves it unchanged.
    always_comb begin
        // NOTE: default assigned first so every path drives it and no latch is inferred.
        occupancy_next = occupancy;
        case ({push, do_pop})
            2'b10:   occupancy_next = occupancy + OW'(1);
            2'b01:   occupancy_next = occupancy - OW'(1);
            default: occupancy_next = occupancy;
        endcase
    end

    // Ring storage, pointers and occupancy; clear has priority over traffic.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            // NOTE: the storage is reset because the head slot is visible on the output port.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            not_empty <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            not_empty <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (do_pop) head <= ptr_inc(head);
            occupancy <= occupancy_next;
            not_empty <= (occupancy_next != '0);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/xillybus_hls_in_bridge.sv
// Prefetch bridge from the Xillybus host-to-PL FIFO (one-cycle read latency)
// to an HLS ap_fifo input. Holds the session FSM, the read-credit logic, the
// delivered-word counter and the sticky read-while-empty flag.
// Optional build macro XILLYBUS_BRIDGE_STALL_STATS_EN enables the saturating
// starvation counter on stall_count; otherwise stall_count is tied to zero.
module xillybus_hls_in_bridge
    import xillybus_bridge_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             bus_clk,
    input  logic             bus_rst_n,
    input  logic             stream_open,
    input  logic [DW-1:0]    fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [DW-1:0]    in_r_dout,
    output logic             in_r_empty_n,
    input  logic             in_r_read,
    output logic [CNT_W-1:0] word_count,
    output logic             rd_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int            OW        = clog2_min1(DEPTH + 1);
    localparam logic [OW:0]   DEPTH_LIM = (OW + 1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic          inflight;
    logic          pop;
    logic          clr;
    logic [OW-1:0] occupancy;
    logic [OW:0]   committed;

    // A pop is only real when the head word is valid.
    assign pop = in_r_read & in_r_empty_n;

    // Session storage is flushed while closed and on the edge that closes it,
    // so the cycle after stream_open falls already shows an empty bridge.
    assign clr = (state == ST_CLOSED) | ~stream_open;

    // Session state register.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) state <= ST_CLOSED;
        else            state <= state_next;
    end

    // Next state and read credit: words held plus word in flight, less the
    // one leaving this cycle, must leave room for one more.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        committed  = {1'b0, occupancy} + (OW + 1)'(inflight) - (OW + 1)'(pop);
        case (state)
            ST_CLOSED: begin
                if (stream_open) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!stream_open) state_next = ST_CLOSED;
                fifo_rd_en = !fifo_empty && (committed < DEPTH_LIM);
            end
            default: state_next = ST_CLOSED;
        endcase
    end

    // Tracks the read issued last cycle; its data is on fifo_dout now.
    // A read issued on the closing cycle is dropped with the session.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) inflight <= 1'b0;
        else if (clr)   inflight <= 1'b0;
        else            inflight <= fifo_rd_en;
    end

    bridge_prefetch_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_buf (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .clr       (clr),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (in_r_dout),
        .not_empty (in_r_empty_n),
        .occupancy (occupancy)
    );

    // Words handed to the HLS core this session; wraps naturally.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n)  word_count <= '0;
        else if (clr)    word_count <= '0;
        else if (pop)    word_count <= word_count + CNT_W'(1);
    end

    // Sticky flag for an HLS read attempted with no valid word.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n)                      rd_err <= 1'b0;
        else if (clr)                        rd_err <= 1'b0;
        else if (in_r_read && !in_r_empty_n) rd_err <= 1'b1;
    end

`ifdef XILLYBUS_BRIDGE_STALL_STATS_EN
    // Cycles the HLS core waits because the host has nothing queued; saturates.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n)
            stall_count <= '0;
        else if (clr)
            stall_count <= '0;
        else if (!in_r_empty_n && fifo_empty && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_xillybus_hls_in_bridge.sv
// Directed bench for xillybus_hls_in_bridge: models the upstream FIFO with a
// one-cycle read latency, keeps a scoreboard of words in FIFO read order and
// checks latency, throughput, credit, session close, error flag, stall
// statistics and asynchronous reset.
module tb_xillybus_hls_in_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

`ifdef XILLYBUS_BRIDGE_STALL_STATS_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic             bus_clk = 1'b0;
    logic             bus_rst_n;
    logic             stream_open;
    logic [DW-1:0]    fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DW-1:0]    in_r_dout;
    logic             in_r_empty_n;
    logic             in_r_read;
    logic [CNT_W-1:0] word_count;
    logic             rd_err;
    logic [CNT_W-1:0] stall_count;

    xillybus_hls_in_bridge #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .bus_clk      (bus_clk),
        .bus_rst_n    (bus_rst_n),
        .stream_open  (stream_open),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .in_r_dout    (in_r_dout),
        .in_r_empty_n (in_r_empty_n),
        .in_r_read    (in_r_read),
        .word_count   (word_count),
        .rd_err       (rd_err),
        .stall_count  (stall_count)
    );

    always #5 bus_clk = ~bus_clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    bit          hold_empty;
    bit          rd_pre;
    bit          pop_pre;
    logic [31:0] dout_pre;
    int          rd_pulses;
    int          pops;
    int          outstanding;
    int          exp_wc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh_empty();
        fifo_empty = hold_empty || (fifo_q.size() == 0);
    endtask

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh_empty();
    endtask

    // One clock cycle: sample mid-cycle, then advance the FIFO model after the edge.
    task automatic cycle();
        #3;
        rd_pre   = fifo_rd_en;
        pop_pre  = in_r_read && in_r_empty_n;
        dout_pre = in_r_dout;
        if (rd_pre) begin
            rd_pulses++;
            check("credit", 32'((outstanding - int'(pop_pre)) < DEPTH), 32'd1);
        end
        if (pop_pre) begin
            pops++;
            exp_wc++;
            check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_data", dout_pre, exp_q.pop_front());
        end
        outstanding += int'(rd_pre) - int'(pop_pre);
        @(posedge bus_clk);
        #1;
        if (rd_pre) begin
            check("fifo_avail", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        end
        refresh_empty();
    endtask

    task automatic session_closed();
        exp_q.delete();
        outstanding = 0;
        exp_wc      = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_rst_n   = 1'b0;
        stream_open = 1'b0;
        in_r_read   = 1'b0;
        fifo_dout   = '0;
        hold_empty  = 1'b1;
        rd_pulses   = 0;
        pops        = 0;
        outstanding = 0;
        exp_wc      = 0;
        refresh_empty();

        // Reset values
        #12;
        check("rst_rd_en",   32'(fifo_rd_en),   32'd0);
        check("rst_empty_n", 32'(in_r_empty_n), 32'd0);
        check("rst_dout",    in_r_dout,         32'd0);
        check("rst_wc",      word_count,        32'd0);
        check("rst_rd_err",  32'(rd_err),       32'd0);
        check("rst_stall",   stall_count,       32'd0);
        bus_rst_n = 1'b1;
        @(posedge bus_clk);
        #1;

        // 1: latency and back-to-back delivery
        stream_open = 1'b1;
        cycle();
        hold_empty = 1'b0;
        for (int i = 0; i < 4; i++) load(32'hA0 + 32'(i));
        in_r_read = 1'b1;
        cycle();
        check("t1_c1_empty_n", 32'(in_r_empty_n), 32'd0);
        cycle();
        check("t1_c2_valid", 32'(in_r_empty_n), 32'd1);
        check("t1_c2_dout",  in_r_dout,         32'hA0);
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("t1_valid", 32'(in_r_empty_n), 32'd1);
            check("t1_dout",  in_r_dout,         32'hA0 + 32'(i));
        end
        cycle();
        check("t1_wc",      word_count,        32'd4);
        check("t1_drained", 32'(in_r_empty_n), 32'd0);

        // 2: back-pressure fills the buffer, then full-rate drain
        in_r_read = 1'b0;
        for (int i = 0; i < 8; i++) load(32'hB0 + 32'(i));
        rd_pulses = 0;
        repeat (10) cycle();
        check("t2_rd_pulses", 32'(rd_pulses),   32'(DEPTH));
        check("t2_valid",     32'(in_r_empty_n), 32'd1);
        check("t2_head",      in_r_dout,         32'hB0);
        in_r_read = 1'b1;
        pops = 0;
        repeat (8) cycle();
        check("t2_no_gaps", 32'(pops), 32'd8);
        in_r_read = 1'b0;
        check("t2_drained", 32'(in_r_empty_n), 32'd0);
        check("t2_wc",      word_count,        32'd12);

        // 3: random handshake on both sides over 1000 words
        void'($urandom(32'd2024));
        for (int i = 0; i < 1000; i++) load($urandom());
        pops = 0;
        for (int c = 0; c < 20000 && pops < 1000; c++) begin
            in_r_read  = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            refresh_empty();
            cycle();
        end
        in_r_read  = 1'b0;
        hold_empty = 1'b0;
        refresh_empty();
        check("t3_pops", 32'(pops),  32'd1000);
        check("t3_wc",   word_count, 32'(exp_wc));

        // 4: close with one word buffered and one in flight, then reopen
        load(32'hC0);
        load(32'hC1);
        cycle();
        cycle();
        stream_open = 1'b0;
        hold_empty  = 1'b1;
        refresh_empty();
        cycle();
        session_closed();
        check("t4_empty_n", 32'(in_r_empty_n), 32'd0);
        check("t4_wc",      word_count,        32'd0);
        hold_empty = 1'b0;
        load(32'h55);
        stream_open = 1'b1;
        cycle();
        for (int i = 0; i < 8 && !in_r_empty_n; i++) cycle();
        check("t4_reopen_valid", 32'(in_r_empty_n), 32'd1);
        check("t4_first_word",   in_r_dout,         32'h55);
        in_r_read = 1'b1;
        cycle();
        in_r_read = 1'b0;
        check("t4_wc_after", word_count, 32'd1);

        // 5: read while empty sets a sticky error, cleared only by closing
        hold_empty = 1'b1;
        refresh_empty();
        check("t5_err_before", 32'(rd_err), 32'd0);
        in_r_read = 1'b1;
        cycle();
        in_r_read = 1'b0;
        check("t5_err_set", 32'(rd_err),  32'd1);
        check("t5_wc_same", word_count,   32'(exp_wc));
        repeat (3) cycle();
        check("t5_err_sticky", 32'(rd_err), 32'd1);
        stream_open = 1'b0;
        cycle();
        session_closed();
        check("t5_err_cleared", 32'(rd_err), 32'd0);

        // 6: starvation statistics over 5 RUN cycles
        stream_open = 1'b1;
        cycle();
        repeat (5) cycle();
        check("t6_stall", stall_count, 32'(EXP_STALL));

        // 7: asynchronous reset in the middle of a burst
        hold_empty = 1'b0;
        for (int i = 0; i < 6; i++) load(32'hD0 + 32'(i));
        in_r_read = 1'b1;
        repeat (4) cycle();
        check("t7_pre_valid", 32'(in_r_empty_n), 32'd1);
        #2;
        bus_rst_n = 1'b0;
        #1;
        check("t7_rd_en",   32'(fifo_rd_en),   32'd0);
        check("t7_empty_n", 32'(in_r_empty_n), 32'd0);
        check("t7_dout",    in_r_dout,         32'd0);
        check("t7_wc",      word_count,        32'd0);
        check("t7_rd_err",  32'(rd_err),       32'd0);
        check("t7_stall",   stall_count,       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
